// File: rtl/mips_pkg.sv
// Shared constants and helpers for the SAD MIPS pipeline front end.
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    // sll $0,$0,0 -- the architectural no-op used for pipeline bubbles
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [ADDR_W-1:0]  RESET_PC  = 32'h0000_0000;

    // Instruction fetches are word granular: clear the byte-offset bits of an address
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's control inputs, instruction-memory port and IF/ID outputs.
interface fetch_stage_if;
    import mips_pkg::*;

    logic               Stall;
    logic               Flush;
    logic               Jump;
    logic [ADDR_W-1:0]  JumpTarget;
    logic               BranchTaken;
    logic [ADDR_W-1:0]  BranchTarget;
    logic [ADDR_W-1:0]  ImemAddress;
    logic [INSTR_W-1:0] ImemInstruction;
    logic [INSTR_W-1:0] IFID_Instruction;
    logic [ADDR_W-1:0]  IFID_PCPlus4;
    logic               IFID_Valid;
    logic [31:0]        FetchCount;

    // Fetch stage side: drives the memory address and the IF/ID outputs
    modport master (
        input  Stall, Flush, Jump, JumpTarget, BranchTaken, BranchTarget, ImemInstruction,
        output ImemAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid, FetchCount
    );

    // Environment side: hazard unit, later stages and the instruction memory
    modport slave (
        output Stall, Flush, Jump, JumpTarget, BranchTaken, BranchTarget, ImemInstruction,
        input  ImemAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid, FetchCount
    );

endinterface

// File: rtl/if_id_register.sv
// IF/ID pipeline register: loads a fetched instruction, holds on stall, or takes a bubble.
// Bubble outranks Hold so a flushed or redirected stage never keeps a stale instruction.
module if_id_register
    import mips_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Hold,
    input  logic               Bubble,
    input  logic [INSTR_W-1:0] D_Instruction,
    input  logic [ADDR_W-1:0]  D_PCPlus4,
    output logic [INSTR_W-1:0] Q_Instruction,
    output logic [ADDR_W-1:0]  Q_PCPlus4,
    output logic               Q_Valid
);

    logic [INSTR_W-1:0] instr_d, instr_q;
    logic [ADDR_W-1:0]  pcplus4_d, pcplus4_q;
    logic               valid_d, valid_q;

    // Next-state selection: bubble, hold, or load the freshly fetched word
    always_comb begin
        instr_d   = instr_q;
        pcplus4_d = pcplus4_q;
        valid_d   = valid_q;
        if (Bubble) begin
            instr_d   = NOP_INSTR;
            pcplus4_d = '0;
            valid_d   = 1'b0;
        end else if (!Hold) begin
            instr_d   = D_Instruction;
            pcplus4_d = D_PCPlus4;
            valid_d   = 1'b1;
        end
    end

    // Register update with synchronous reset to an empty (bubble) stage
    always_ff @(posedge Clk) begin
        if (Reset) begin
            instr_q   <= NOP_INSTR;
            pcplus4_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            pcplus4_q <= pcplus4_d;
            valid_q   <= valid_d;
        end
    end

    assign Q_Instruction = instr_q;
    assign Q_PCPlus4     = pcplus4_q;
    assign Q_Valid       = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC priority mux, IF/ID register and fetch counter.
// Redirect priority: taken branch (older, in EX) > jump (ID) > stall > sequential.
// There is no delay slot; the word fetched during a redirect edge is replaced by a bubble.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  RESET_PC  = mips_pkg::RESET_PC,
    parameter logic [INSTR_W-1:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic         Clk,
    input  logic         Reset,
    fetch_stage_if.master bus
);

    logic [ADDR_W-1:0] pc_d, pc_q;
    logic [31:0]       fetch_count_d, fetch_count_q;
    logic [ADDR_W-1:0] pc_plus4;
    logic              redirect;
    logic              ifid_bubble;
    logic              ifid_hold;
    logic              ifid_load;

    // PC+4 wraps naturally at 2^32
    assign pc_plus4 = pc_q + ADDR_W'(4);

    // Next-PC priority mux and IF/ID control decode
    always_comb begin
        pc_d        = pc_q;
        redirect    = bus.BranchTaken | bus.Jump;
        ifid_bubble = redirect | bus.Flush;
        ifid_hold   = bus.Stall;
        ifid_load   = !ifid_bubble && !ifid_hold;
        if (bus.BranchTaken) begin
            pc_d = word_align(bus.BranchTarget);
        end else if (bus.Jump) begin
            pc_d = word_align(bus.JumpTarget);
        end else if (!bus.Stall) begin
            pc_d = pc_plus4;
        end
    end

    // Count real instructions entering IF/ID, saturating at all-ones
    always_comb begin
        fetch_count_d = fetch_count_q;
        if (ifid_load && (fetch_count_q != 32'hFFFF_FFFF)) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    // PC and counter registers; reset overrides every other input
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q          <= word_align(RESET_PC);
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    if_id_register #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .Clk           (Clk),
        .Reset         (Reset),
        .Hold          (ifid_hold),
        .Bubble        (ifid_bubble),
        .D_Instruction (bus.ImemInstruction),
        .D_PCPlus4     (pc_plus4),
        .Q_Instruction (bus.IFID_Instruction),
        .Q_PCPlus4     (bus.IFID_PCPlus4),
        .Q_Valid       (bus.IFID_Valid)
    );

    assign bus.ImemAddress = pc_q;
    assign bus.FetchCount  = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios, a behavioural fetch model checked every cycle,
// and literal expectations at the key points of each scenario.
module tb_fetch_stage;

    logic Clk = 1'b0;
    logic Reset;

    fetch_stage_if bus ();

    fetch_stage dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    // Small combinational instruction memory, aliased on address bits [7:2]
    logic [31:0] mem [0:63];
    assign bus.ImemInstruction = mem[bus.ImemAddress[7:2]];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: state of the fetch stage as the ISA-level description defines it
    logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
    logic        m_valid;
    logic        m_live = 1'b0;

    always @(posedge Clk) begin
        if (Reset) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 0;
            m_live = 1'b1;
        end else if (m_live) begin
            if (bus.BranchTaken || bus.Jump) begin
                m_pc = {(bus.BranchTaken ? bus.BranchTarget[31:2] : bus.JumpTarget[31:2]), 2'b00};
                m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            end else if (bus.Stall) begin
                if (bus.Flush) begin
                    m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
                end
            end else begin
                if (bus.Flush) begin
                    m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
                end else begin
                    m_instr = mem[m_pc[7:2]]; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
                    if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                end
                m_pc = m_pc + 32'd4;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge Clk) begin
        if (m_live) begin
            chk("m_pc",    bus.ImemAddress,      m_pc);
            chk("m_instr", bus.IFID_Instruction, m_instr);
            chk("m_pc4",   bus.IFID_PCPlus4,     m_pc4);
            chk("m_valid", {31'b0, bus.IFID_Valid}, {31'b0, m_valid});
            chk("m_count", bus.FetchCount,       m_cnt);
        end
    end

    // One clock edge with the given controls; inputs change just after a falling edge
    task automatic step(input logic st, input logic fl, input logic jp, input logic [31:0] jt,
                        input logic br, input logic [31:0] bt);
        bus.Stall = st; bus.Flush = fl; bus.Jump = jp; bus.JumpTarget = jt;
        bus.BranchTaken = br; bus.BranchTarget = bt;
        @(posedge Clk);
        @(negedge Clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic pin(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                       input logic [31:0] p4, input logic v, input logic [31:0] cnt);
        chk({tag, "_pc"},    bus.ImemAddress,         pc);
        chk({tag, "_instr"}, bus.IFID_Instruction,    ins);
        chk({tag, "_pc4"},   bus.IFID_PCPlus4,        p4);
        chk({tag, "_valid"}, {31'b0, bus.IFID_Valid}, {31'b0, v});
        chk({tag, "_count"}, bus.FetchCount,          cnt);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i * 32'h111);
        mem[0] = 32'h23BD_FFFC;
        Reset = 1'b1;
        bus.Stall = 0; bus.Flush = 0; bus.Jump = 0; bus.JumpTarget = 0;
        bus.BranchTaken = 0; bus.BranchTarget = 0;
        @(negedge Clk);

        // Reset held for three edges
        run(3);
        pin("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        Reset = 1'b0;

        // First fetch after release
        run(1);
        pin("first", 32'h4, 32'h23BD_FFFC, 32'h4, 1'b1, 32'd1);

        // Reach PC=8, then stall two cycles
        run(1);
        pin("pc8", 32'h8, mem[1], 32'h8, 1'b1, 32'd2);
        step(1, 0, 0, 32'h0, 0, 32'h0);
        step(1, 0, 0, 32'h0, 0, 32'h0);
        pin("stall", 32'h8, mem[1], 32'h8, 1'b1, 32'd2);
        run(1);
        pin("unstall", 32'hC, mem[2], 32'hC, 1'b1, 32'd3);

        // Free-run up to PC=0x14
        run(2);
        pin("run5", 32'h14, mem[4], 32'h14, 1'b1, 32'd5);

        // Jump to 0x24: bubble, then imem[9]
        step(0, 0, 1, 32'h24, 0, 32'h0);
        pin("jump", 32'h24, 32'h0, 32'h0, 1'b0, 32'd5);
        run(1);
        pin("after_jump", 32'h28, mem[9], 32'h28, 1'b1, 32'd6);

        // Branch beats jump and stall; target low bits masked
        step(1, 0, 1, 32'h24, 1, 32'hD6);
        pin("branch", 32'hD4, 32'h0, 32'h0, 1'b0, 32'd6);
        run(1);
        chk("after_branch_instr", bus.IFID_Instruction, mem[53]);

        // Flush alone advances the PC with a bubble; stall+flush holds PC with a bubble
        step(0, 1, 0, 32'h0, 0, 32'h0);
        pin("flush", 32'hDC, 32'h0, 32'h0, 1'b0, 32'd7);
        run(1);
        step(1, 1, 0, 32'h0, 0, 32'h0);
        pin("stall_flush", 32'hE0, 32'h0, 32'h0, 1'b0, 32'd8);

        // PC wrap: jump to top word (misaligned target), then free-run
        step(0, 0, 1, 32'hFFFF_FFFE, 0, 32'h0);
        chk("top_pc", bus.ImemAddress, 32'hFFFF_FFFC);
        run(1);
        pin("wrap", 32'h0, mem[63], 32'h0, 1'b1, 32'd9);

        // Reset while stalled with a pending jump
        bus.Stall = 1; bus.Jump = 1; bus.JumpTarget = 32'h40;
        Reset = 1'b1;
        @(posedge Clk); @(negedge Clk); #1;
        pin("reset_mid", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        @(posedge Clk); @(negedge Clk); #1;
        chk("reset_hold_pc", bus.ImemAddress, 32'h0);
        Reset = 1'b0;
        run(1);
        pin("restart", 32'h4, 32'h23BD_FFFC, 32'h4, 1'b1, 32'd1);

        run(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
